lc3_mem_ctrl: RTL and testbench

LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

---
 rtl/lc3_pkg.sv | 18 +
 rtl/lc3_mem_array.sv | 24 ++
 rtl/lc3_mem_ctrl.sv | 157 +++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 memory controller: memory-mapped device
// addresses and the request FSM state encoding.
package lc3_pkg;

  localparam int DATA_W = 16;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lc3_mem_array.sv
// Synchronous single-port RAM. The read is registered on the same edge that
// performs the access, so the word is available in the following cycle.
module lc3_mem_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: wait-state request FSM in front of a backing RAM
// plus the keyboard (KBSR/KBDR) and display (DSR/DDR) device registers.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int MEM_WORDS   = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_in,
  output logic [15:0] mdr_out,
  output logic        ready,
  input  logic        kb_valid,
  input  logic [7:0]  kb_char,
  output logic        ddr_valid,
  output logic [7:0]  ddr_char,
  input  logic        disp_ready
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept, access;

  logic        req_we_p0;
  logic [15:0] req_addr_p0, req_data_p0;

  logic        in_ram;
  logic [15:0] dev_rdata;
  logic [15:0] ram_q;
  logic        rd_ram_p1;
  logic [15:0] dev_p1;

  logic        kb_full, kb_ie;
  logic [7:0]  kb_data;
  logic        kb_rd, kb_load, ddr_wr, consume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // WAIT leaves on the edge that brings the counter to zero, so RESP lands
  // WAIT_CYCLES edges after acceptance and ready one edge after that.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: if (mem_en) begin
        cnt_next   = 4'(WAIT_CYCLES);
        state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) state_next = S_RESP;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    accept = (state == S_IDLE) && mem_en;
    access = (state == S_RESP);
  end

  // Request capture stage
  always_ff @(posedge clk) begin
    if (accept) begin
      req_we_p0   <= mem_we;
      req_addr_p0 <= mar;
      req_data_p0 <= mdr_in;
    end
  end

  assign in_ram = {16'h0000, req_addr_p0} < 32'(MEM_WORDS);

  always_comb begin
    dev_rdata = '0;
    if (req_addr_p0 == KBSR_ADDR)      dev_rdata = {kb_full, kb_ie, 14'b0};
    else if (req_addr_p0 == KBDR_ADDR) dev_rdata = {8'h00, kb_data};
    else if (req_addr_p0 == DSR_ADDR)  dev_rdata = {~ddr_valid, 15'b0};
    else if (req_addr_p0 == DDR_ADDR)  dev_rdata = {8'h00, ddr_char};
  end

  lc3_mem_array #(
    .DEPTH(MEM_WORDS),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .en   (access && in_ram),
    .we   (req_we_p0),
    .addr (req_addr_p0[AW-1:0]),
    .wdata(req_data_p0),
    .rdata(ram_q)
  );

  // Response stage: ready and read data appear the cycle after RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready     <= 1'b0;
      rd_ram_p1 <= 1'b0;
      dev_p1    <= '0;
    end else begin
      ready     <= access;
      rd_ram_p1 <= access && in_ram && !req_we_p0;
      dev_p1    <= (access && !req_we_p0) ? dev_rdata : '0;
    end
  end

  assign mdr_out = ready ? (rd_ram_p1 ? ram_q : dev_p1) : '0;

  // A KBDR read frees the buffer on the same edge a new character arrives.
  assign kb_rd   = access && !req_we_p0 && (req_addr_p0 == KBDR_ADDR);
  assign kb_load = kb_valid && (!kb_full || kb_rd);
  assign consume = ddr_valid && disp_ready;
  assign ddr_wr  = access && req_we_p0 && (req_addr_p0 == DDR_ADDR) && !ddr_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_full <= 1'b0;
      kb_ie   <= 1'b0;
      kb_data <= '0;
    end else begin
      if (kb_load) begin
        kb_data <= kb_char;
        kb_full <= 1'b1;
      end else if (kb_rd) begin
        kb_full <= 1'b0;
      end
      if (access && req_we_p0 && (req_addr_p0 == KBSR_ADDR)) kb_ie <= req_data_p0[14];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ddr_valid <= 1'b0;
      ddr_char  <= '0;
    end else if (ddr_wr) begin
      ddr_char  <= req_data_p0[7:0];
      ddr_valid <= 1'b1;
    end else if (consume) begin
      ddr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: one instance with two wait states over a
// 16K-word RAM and one zero-wait instance for the minimum-latency path.
module tb_lc3_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_en, mem_en0, mem_we;
  logic [15:0] mar, mdr_in;
  logic [15:0] mdr_out, mdr_out0;
  logic        ready, ready0;
  logic        kb_valid;
  logic [7:0]  kb_char;
  logic        ddr_valid, ddr_valid0;
  logic [7:0]  ddr_char, ddr_char0;
  logic        disp_ready;

  int n_checks = 0;
  int n_fail   = 0;

  lc3_mem_ctrl #(.WAIT_CYCLES(2), .MEM_WORDS(16384)) dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .mem_we(mem_we), .mar(mar),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .ready(ready), .kb_valid(kb_valid),
    .kb_char(kb_char), .ddr_valid(ddr_valid), .ddr_char(ddr_char),
    .disp_ready(disp_ready)
  );

  lc3_mem_ctrl #(.WAIT_CYCLES(0), .MEM_WORDS(4096)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en0), .mem_we(mem_we), .mar(mar),
    .mdr_in(mdr_in), .mdr_out(mdr_out0), .ready(ready0), .kb_valid(kb_valid),
    .kb_char(kb_char), .ddr_valid(ddr_valid0), .ddr_char(ddr_char0),
    .disp_ready(disp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction; latency counts edges from acceptance to ready.
  task automatic xact(input string tag, input bit w0, input bit we,
                      input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp_q, input int exp_lat);
    int lat;
    logic [15:0] q;
    if (w0) mem_en0 = 1'b1; else mem_en = 1'b1;
    mem_we = we; mar = a; mdr_in = d;
    tick();
    mem_en = 1'b0; mem_en0 = 1'b0;
    lat = 0;
    while (((w0 ? ready0 : ready) !== 1'b1) && lat < 20) begin
      tick();
      lat++;
    end
    q = w0 ? mdr_out0 : mdr_out;
    chk({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    if (!we) chk({tag, "_q"}, q, exp_q);
    tick();
    chk({tag, "_drop"}, {15'b0, w0 ? ready0 : ready}, 16'h0000);
  endtask

  // Launch a request on the two-wait instance and stop in its RESP cycle.
  task automatic to_resp(input bit we, input logic [15:0] a, input logic [15:0] d);
    mem_en = 1'b1; mem_we = we; mar = a; mdr_in = d;
    tick();
    mem_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic kb_strobe(input logic [7:0] c);
    kb_valid = 1'b1; kb_char = c;
    tick();
    kb_valid = 1'b0;
  endtask

  initial begin
    logic any_ready;
    rst_n = 1'b0; mem_en = 1'b0; mem_en0 = 1'b0; mem_we = 1'b0;
    mar = '0; mdr_in = '0; kb_valid = 1'b0; kb_char = '0; disp_ready = 1'b0;
    #3;
    chk("rst_ready",     {15'b0, ready},      16'h0000);
    chk("rst_mdr_out",   mdr_out,             16'h0000);
    chk("rst_ddr_valid", {15'b0, ddr_valid},  16'h0000);
    chk("rst_ddr_char",  {8'h00, ddr_char},   16'h0000);
    chk("rst_ready0",    {15'b0, ready0},     16'h0000);
    chk("rst_ddr_valid0",{15'b0, ddr_valid0}, 16'h0000);
    chk("rst_ddr_char0", {8'h00, ddr_char0},  16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Zero-wait instance
    xact("w0_wr",    1'b1, 1'b1, 16'h0020, 16'hCAFE, 16'h0000, 1);
    xact("w0_rd",    1'b1, 1'b0, 16'h0020, 16'h0000, 16'hCAFE, 1);
    xact("w0_rd_c000", 1'b1, 1'b0, 16'hC000, 16'h0000, 16'h0000, 1);

    // RAM through the two-wait instance
    xact("wr_3000",  1'b0, 1'b1, 16'h3000, 16'hBEEF, 16'h0000, 3);
    xact("rd_3000",  1'b0, 1'b0, 16'h3000, 16'h0000, 16'hBEEF, 3);
    xact("wr_3fff",  1'b0, 1'b1, 16'h3FFF, 16'hA5A5, 16'h0000, 3);
    xact("rd_3fff",  1'b0, 1'b0, 16'h3FFF, 16'h0000, 16'hA5A5, 3);
    xact("wr_4000",  1'b0, 1'b1, 16'h4000, 16'h7777, 16'h0000, 3);
    xact("rd_4000",  1'b0, 1'b0, 16'h4000, 16'h0000, 16'h0000, 3);
    xact("rd_c000",  1'b0, 1'b0, 16'hC000, 16'h0000, 16'h0000, 3);
    xact("rd_3000b", 1'b0, 1'b0, 16'h3000, 16'h0000, 16'hBEEF, 3);

    // Keyboard
    kb_strobe(8'h41);
    xact("kbsr_full",  1'b0, 1'b0, 16'hFE00, 16'h0000, 16'h8000, 3);
    xact("kbdr_41",    1'b0, 1'b0, 16'hFE02, 16'h0000, 16'h0041, 3);
    xact("kbsr_empty", 1'b0, 1'b0, 16'hFE00, 16'h0000, 16'h0000, 3);
    kb_strobe(8'h41);
    kb_strobe(8'h43);
    to_resp(1'b0, 16'hFE02, 16'h0000);
    chk("kbdr_resp_rdy0", {15'b0, ready}, 16'h0000);
    chk("kbdr_resp_mdr0", mdr_out,        16'h0000);
    kb_valid = 1'b1; kb_char = 8'h42;
    tick();
    kb_valid = 1'b0;
    chk("kbdr_race_rdy", {15'b0, ready}, 16'h0001);
    chk("kbdr_race_q",   mdr_out,        16'h0041);
    tick();
    xact("kbsr_refull",  1'b0, 1'b0, 16'hFE00, 16'h0000, 16'h8000, 3);
    xact("kbdr_42",      1'b0, 1'b0, 16'hFE02, 16'h0000, 16'h0042, 3);
    xact("kbsr_empty2",  1'b0, 1'b0, 16'hFE00, 16'h0000, 16'h0000, 3);
    xact("kbsr_wr",      1'b0, 1'b1, 16'hFE00, 16'hFFFF, 16'h0000, 3);
    xact("kbsr_ie",      1'b0, 1'b0, 16'hFE00, 16'h0000, 16'h4000, 3);
    xact("kbdr_wr",      1'b0, 1'b1, 16'hFE02, 16'h00FF, 16'h0000, 3);
    xact("kbdr_keep",    1'b0, 1'b0, 16'hFE02, 16'h0000, 16'h0042, 3);

    // Display
    xact("dsr_idle",   1'b0, 1'b0, 16'hFE04, 16'h0000, 16'h8000, 3);
    xact("ddr_wr58",   1'b0, 1'b1, 16'hFE06, 16'h1258, 16'h0000, 3);
    chk("ddr_valid_set", {15'b0, ddr_valid}, 16'h0001);
    chk("ddr_char_58",   {8'h00, ddr_char},  16'h0058);
    xact("dsr_busy",   1'b0, 1'b0, 16'hFE04, 16'h0000, 16'h0000, 3);
    xact("ddr_rd",     1'b0, 1'b0, 16'hFE06, 16'h0000, 16'h0058, 3);
    xact("ddr_wr59",   1'b0, 1'b1, 16'hFE06, 16'h0059, 16'h0000, 3);
    chk("ddr_char_kept", {8'h00, ddr_char},  16'h0058);
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    chk("ddr_consumed",  {15'b0, ddr_valid}, 16'h0000);
    chk("ddr_char_hold", {8'h00, ddr_char},  16'h0058);
    xact("dsr_free",   1'b0, 1'b0, 16'hFE04, 16'h0000, 16'h8000, 3);
    xact("ddr_wr61",   1'b0, 1'b1, 16'hFE06, 16'h0061, 16'h0000, 3);
    to_resp(1'b1, 16'hFE06, 16'h0062);
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    chk("ddr_race_valid", {15'b0, ddr_valid}, 16'h0000);
    chk("ddr_race_char",  {8'h00, ddr_char},  16'h0061);
    tick();

    // Reset in the middle of a write
    xact("wr_0010",    1'b0, 1'b1, 16'h0010, 16'h5555, 16'h0000, 3);
    xact("ddr_wr70",   1'b0, 1'b1, 16'hFE06, 16'h0070, 16'h0000, 3);
    mem_en = 1'b1; mem_we = 1'b1; mar = 16'h0010; mdr_in = 16'h1234;
    tick();
    mem_en = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_ddr_valid", {15'b0, ddr_valid}, 16'h0000);
    chk("arst_ddr_char",  {8'h00, ddr_char},  16'h0000);
    chk("arst_mdr_out",   mdr_out,            16'h0000);
    any_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_ready = any_ready | ready;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_ready = any_ready | ready;
    end
    chk("abort_no_ready", {15'b0, any_ready}, 16'h0000);
    xact("rd_0010",     1'b0, 1'b0, 16'h0010, 16'h0000, 16'h5555, 3);
    xact("kbsr_after_rst", 1'b0, 1'b0, 16'hFE00, 16'h0000, 16'h0000, 3);
    xact("kbdr_after_rst", 1'b0, 1'b0, 16'hFE02, 16'h0000, 16'h0000, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
